// File: rtl/sram_stream_loader.sv
// sram_stream_loader
// Loads framed bytes from an upstream byte source into the s2 port of the
// dual-port SRAM while the CPU is held in reset.
// Frame: SYNC_BYTE, start address (lo, hi), word count N (lo, hi),
// 4*N little-endian payload bytes, then one checksum byte.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_data/in_valid    upstream byte and its valid flag
//   in_ready            loader accepts a byte on this edge
//   address2 .. clken2  SRAM s2 port (single-cycle word writes)
//   busy / hold_cpu     a frame is in progress
//   done                one-cycle pulse on a frame with a good checksum
//   error               sticky; cleared by the next sync byte or reset
module sram_stream_loader #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address2,
  output logic [3:0]        byteenable2,
  output logic              chipselect2,
  output logic              write2,
  output logic [31:0]       writedata2,
  output logic              clken2,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              hold_cpu
);

  typedef enum logic [3:0] {
    IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR
  } state_e;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         start_q, start_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         lane_q, lane_d;
  logic [7:0]          csum_q, csum_d;
  logic                in_ready_q, in_ready_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   address2_q, address2_d;
  logic [31:0]         writedata2_q, writedata2_d;

  logic                accept;
  logic [15:0]         hdr_len;
  logic [16:0]         range_end;
  logic [7:0]          csum_next;

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    lane_d       = lane_q;
    csum_d       = csum_q;
    error_d      = error_q;
    address2_d   = address2_q;
    writedata2_d = writedata2_q;

    accept    = in_valid & in_ready_q;
    hdr_len   = {in_data, len_q[7:0]};
    range_end = {1'b0, start_q} + {1'b0, hdr_len};
    csum_next = csum_q + in_data;

    unique case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = ADDR_LO;
          csum_d  = '0;
          error_d = 1'b0;
        end
      end
      ADDR_LO: begin
        if (accept) begin
          start_d[7:0] = in_data;
          state_d      = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (accept) begin
          start_d[15:8] = in_data;
          if (({in_data, start_q[7:0]} >> ADDR_W) != 16'd0) state_d = ERR;
          else                                             state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          byte_idx_d  = '0;
          word_idx_d  = '0;
          if (range_end > DEPTH)    state_d = ERR;
          else if (hdr_len == 16'd0) state_d = CSUM;
          else                       state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d     = csum_next;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: lane_d[7:0]   = in_data;
            2'd1: lane_d[15:8]  = in_data;
            2'd2: lane_d[23:16] = in_data;
            default: begin
              // The 4th byte goes straight into the output word, so the
              // strobe cycle already carries the complete word.
              writedata2_d = {in_data, lane_q};
              address2_d   = start_q[ADDR_W-1:0] + word_idx_q[ADDR_W-1:0];
              state_d      = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == len_q) state_d = CSUM;
        else                             state_d = DATA;
      end
      CSUM: begin
        if (accept) begin
          if (csum_next == 8'h00) state_d = DONE;
          else                    state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies decoded from the next state.
    in_ready_d = (state_d != WRITE) && (state_d != DONE) && (state_d != ERR);
    strobe_d   = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    if (state_d == ERR) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      lane_q       <= '0;
      csum_q       <= '0;
      in_ready_q   <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      address2_q   <= '0;
      writedata2_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      lane_q       <= lane_d;
      csum_q       <= csum_d;
      in_ready_q   <= in_ready_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      address2_q   <= address2_d;
      writedata2_q <= writedata2_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign address2    = address2_q;
  assign byteenable2 = strobe_q ? 4'hF : 4'h0;
  assign chipselect2 = strobe_q;
  assign write2      = strobe_q;
  assign writedata2  = writedata2_q;
  assign clken2      = 1'b1;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign hold_cpu    = busy_q;

endmodule

// File: tb/tb_sram_stream_loader.sv
module tb_sram_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] address2;
  logic [3:0]  byteenable2;
  logic        chipselect2, write2, clken2, busy, done, error, hold_cpu;
  logic [31:0] writedata2;

  sram_stream_loader #(.ADDR_W(14), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address2(address2), .byteenable2(byteenable2),
    .chipselect2(chipselect2), .write2(write2), .writedata2(writedata2),
    .clken2(clken2), .busy(busy), .done(done), .error(error),
    .hold_cpu(hold_cpu)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic fail(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  logic [45:0] obs_q[$];
  logic [45:0] exp_q[$];
  int          done_cnt = 0;
  logic        prev_wr  = 1'b0;
  logic [31:0] pay [0:63];
  time         t_sync, t_out;

  always @(negedge clk) begin
    if (write2 === 1'b1) begin
      obs_q.push_back({address2, writedata2});
      n_assert++; if (prev_wr !== 1'b0) fail("strobe_single_cycle", prev_wr, 1'b0);
      n_assert++; if (byteenable2 !== 4'hF) fail("byteenable", byteenable2, 4'hF);
    end
    if (reset === 1'b0) begin
      n_assert++; if (chipselect2 !== write2) fail("chipselect_eq_write", chipselect2, write2);
      n_assert++; if (hold_cpu !== busy) fail("hold_cpu_eq_busy", hold_cpu, busy);
      n_assert++; if (clken2 !== 1'b1) fail("clken2_const", clken2, 1'b1);
      if (busy === 1'b1 && done === 1'b0 && error === 1'b0) begin
        n_assert++; if (in_ready !== ~write2) fail("ready_low_only_in_write", in_ready, ~write2);
      end
    end
    if (done === 1'b1) done_cnt++;
    prev_wr = write2;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_assert++; if (t >= 40) fail("ready_timeout", t, 40);
  endtask

  task automatic check_reset_vals();
    n_assert++; if (in_ready !== 1'b0) fail("rst_in_ready", in_ready, 1'b0);
    n_assert++; if (address2 !== 14'h0) fail("rst_address2", address2, 14'h0);
    n_assert++; if (byteenable2 !== 4'h0) fail("rst_byteenable2", byteenable2, 4'h0);
    n_assert++; if (chipselect2 !== 1'b0) fail("rst_chipselect2", chipselect2, 1'b0);
    n_assert++; if (write2 !== 1'b0) fail("rst_write2", write2, 1'b0);
    n_assert++; if (writedata2 !== 32'h0) fail("rst_writedata2", writedata2, 32'h0);
    n_assert++; if (clken2 !== 1'b1) fail("rst_clken2", clken2, 1'b1);
    n_assert++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
    n_assert++; if (done !== 1'b0) fail("rst_done", done, 1'b0);
    n_assert++; if (error !== 1'b0) fail("rst_error", error, 1'b0);
    n_assert++; if (hold_cpu !== 1'b0) fail("rst_hold_cpu", hold_cpu, 1'b0);
  endtask

  task automatic run_frame(input int start, input int n, input int gapmax,
                           input logic [7:0] csum_xor, input bit chk_clear);
    logic [15:0] s16, n16;
    logic [7:0]  sum, b;
    bit          addr_err, hdr_err, exp_ok;
    int          t, d0;
    s16      = 16'(start);
    n16      = 16'(n);
    addr_err = (start >= 16384);
    hdr_err  = addr_err || (start + n > 16384);
    exp_q.delete();
    obs_q.delete();
    d0  = done_cnt;
    sum = 8'h00;
    send_byte(8'hA5, $urandom_range(0, gapmax));
    t_sync = $time;
    if (chk_clear) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_assert++; if (error !== 1'b0) fail("sync_clears_error", error, 1'b0);
      n_assert++; if (busy !== 1'b1) fail("sync_sets_busy", busy, 1'b1);
    end
    send_byte(s16[7:0], $urandom_range(0, gapmax));
    send_byte(s16[15:8], $urandom_range(0, gapmax));
    if (!addr_err) begin
      send_byte(n16[7:0], $urandom_range(0, gapmax));
      send_byte(n16[15:8], $urandom_range(0, gapmax));
    end
    if (!hdr_err) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < 4; k++) begin
          b   = pay[w][8*k +: 8];
          sum = sum + b;
          send_byte(b, $urandom_range(0, gapmax));
        end
        exp_q.push_back({14'(start + w), pay[w]});
      end
      send_byte((8'h00 - sum) ^ csum_xor, $urandom_range(0, gapmax));
    end
    exp_ok = !hdr_err && (csum_xor == 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    t_out = $time;
    n_assert++; if (t >= 20) fail("outcome_timeout", t, 20);
    n_assert++; if (done !== exp_ok) fail("done_pulse", done, exp_ok);
    n_assert++; if (error !== !exp_ok) fail("error_flag", error, !exp_ok);
    @(negedge clk);
    n_assert++; if (busy !== 1'b0) fail("busy_dropped", busy, 1'b0);
    n_assert++; if (done !== 1'b0) fail("done_one_cycle", done, 1'b0);
    n_assert++; if (error !== !exp_ok) fail("error_sticky", error, !exp_ok);
    n_assert++; if ((done_cnt - d0) != (exp_ok ? 1 : 0)) fail("done_count", done_cnt - d0, exp_ok ? 1 : 0);
    n_assert++; if (obs_q.size() != exp_q.size()) fail("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++; if (obs_q[i] !== exp_q[i]) fail("write_addr_data", obs_q[i], exp_q[i]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    pay[0] = 32'h44332211;
    pay[1] = 32'h88776655;
    run_frame(16'h0010, 2, 0, 8'h00, 1'b0);
    run_frame(16'h0010, 2, 0, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    n_assert++; if (error !== 1'b1) fail("error_still_set", error, 1'b1);

    send_byte(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++; if (busy !== 1'b0) fail("garbage_busy0", busy, 1'b0);
    send_byte(8'hFF, 0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++; if (busy !== 1'b0) fail("garbage_busy1", busy, 1'b0);
    send_byte(8'h12, 0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++; if (busy !== 1'b0) fail("garbage_busy2", busy, 1'b0);
    run_frame(16'h0100, 0, 0, 8'h00, 1'b1);

    run_frame(16'h3FFF, 2, 0, 8'h00, 1'b0);
    pay[0] = 32'hDEADBEEF;
    run_frame(16'h3FFF, 1, 0, 8'h00, 1'b0);
    run_frame(16'h4000, 1, 0, 8'h00, 1'b0);
    pay[0] = 32'h44332211;
    pay[1] = 32'h88776655;
    run_frame(16'h0010, 2, 1, 8'h00, 1'b0);

    for (int w = 0; w < 16; w++) pay[w] = $urandom;
    run_frame(16'h0200, 16, 0, 8'h00, 1'b0);
    n_assert++; if ((t_out - t_sync) / 10 != 86) fail("burst_cycles", (t_out - t_sync) / 10, 86);
    run_frame(16'h0200, 16, 3, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int st, nn;
      st = $urandom_range(0, 16383);
      nn = $urandom_range(0, 8);
      if (i % 2 == 0) st = $urandom_range(0, 16000);
      for (int w = 0; w < nn; w++) pay[w] = $urandom;
      run_frame(st, nn, $urandom_range(0, 2),
                (i == 3) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0);
    end

    obs_q.delete();
    pay[0] = 32'hCAFEF00D;
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(pay[0][8*k +: 8], 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_assert++; if (obs_q.size() != 1) fail("reset_write_count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      n_assert++; if (obs_q[0] !== {14'h0020, 32'hCAFEF00D}) fail("reset_first_write", obs_q[0], {14'h0020, 32'hCAFEF00D});
    end
    n_assert++; if (busy !== 1'b0) fail("reset_idle_busy", busy, 1'b0);
    pay[0] = 32'h01020304;
    pay[1] = 32'hA5A5A5A5;
    run_frame(16'h0020, 2, 1, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
